// File: rtl/reg_bank.sv
// Parametrised register bank: DEPTH x WIDTH flops, one load port, one increment
// port, two combinational read ports with per-register valid tracking.

module reg_bank_cell #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ld,
  input  logic             inc,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             vld
);
  // ld and inc are made mutually exclusive by the bank; load wins a collision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q   <= RESET_VAL;
      vld <= 1'b0;
    end else if (ld) begin
      q   <= d;
      vld <= 1'b1;
    end else if (inc) begin
      q   <= q + WIDTH'(1);
    end
  end
endmodule

module reg_bank #(
  parameter int               WIDTH     = 16,
  parameter int               DEPTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit               BYPASS    = 1'b1,
  localparam int              AW        = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] buswires,
  input  logic             inc_en,
  input  logic [AW-1:0]    inc_addr,
  input  logic [AW-1:0]    rd_addr_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_a,
  output logic [WIDTH-1:0] rd_b,
  output logic             rd_a_valid,
  output logic             rd_b_valid,
  output logic [DEPTH-1:0] valid,
  output logic             inc_wrap
);

  logic [DEPTH-1:0][WIDTH-1:0] regs;
  logic [DEPTH-1:0]            ld, inc, ones;
  logic                        byp_ok;

  // Per-register decode; out-of-range addresses simply match no register.
  for (genvar i = 0; i < DEPTH; i++) begin : g_reg
    assign ld[i]   = wr_en && (wr_addr == AW'(i));
    assign inc[i]  = inc_en && (inc_addr == AW'(i)) && !ld[i];
    assign ones[i] = &regs[i];

    reg_bank_cell #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_cell (
      .clk   (clk),
      .reset (reset),
      .ld    (ld[i]),
      .inc   (inc[i]),
      .d     (buswires),
      .q     (regs[i]),
      .vld   (valid[i])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) inc_wrap <= 1'b0;
    else       inc_wrap <= |(inc & ones);
  end

  // Bypass only for an in-range write, and never while reset holds the bank clear.
  assign byp_ok = BYPASS && !reset && (|ld);

  function automatic logic [WIDTH:0] read_port(
    input logic [AW-1:0]                 addr,
    input logic [DEPTH-1:0][WIDTH-1:0]   r,
    input logic [DEPTH-1:0]              v,
    input logic                          byp,
    input logic [AW-1:0]                 waddr,
    input logic [WIDTH-1:0]              wdata
  );
    logic [WIDTH:0] res;
    res = '0;
    for (int i = 0; i < DEPTH; i++)
      if (addr == AW'(i)) res = {v[i], r[i]};
    if (byp && (addr == waddr)) res = {1'b1, wdata};
    return res;
  endfunction

  assign {rd_a_valid, rd_a} = read_port(rd_addr_a, regs, valid, byp_ok, wr_addr, buswires);
  assign {rd_b_valid, rd_b} = read_port(rd_addr_b, regs, valid, byp_ok, wr_addr, buswires);

endmodule

// File: tb/tb_reg_bank.sv
// Directed bench for reg_bank: a BYPASS=1 and a BYPASS=0 instance share all inputs.

module tb_reg_bank;
  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en, inc_en;
  logic [2:0]  wr_addr, inc_addr, rd_addr_a, rd_addr_b;
  logic [15:0] buswires;
  logic [15:0] rd_a, rd_b, rd_a2, rd_b2;
  logic        rd_a_valid, rd_b_valid, rd_a_valid2, rd_b_valid2;
  logic [7:0]  valid, valid2;
  logic        inc_wrap, inc_wrap2;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  reg_bank dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .buswires(buswires),
    .inc_en(inc_en), .inc_addr(inc_addr), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_a(rd_a), .rd_b(rd_b), .rd_a_valid(rd_a_valid), .rd_b_valid(rd_b_valid),
    .valid(valid), .inc_wrap(inc_wrap)
  );

  reg_bank #(.BYPASS(1'b0)) dut_nb (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .buswires(buswires),
    .inc_en(inc_en), .inc_addr(inc_addr), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_a(rd_a2), .rd_b(rd_b2), .rd_a_valid(rd_a_valid2), .rd_b_valid(rd_b_valid2),
    .valid(valid2), .inc_wrap(inc_wrap2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; inc_en = 1'b0;
    wr_addr = '0; inc_addr = '0; rd_addr_a = '0; rd_addr_b = '0; buswires = '0;

    // Reset and idle
    #99;
    chk("rst_rd_a", rd_a, 16'h0000);
    chk("rst_rd_b", rd_b, 16'h0000);
    chk("rst_valid", valid, 8'h00);
    chk("rst_wrap", inc_wrap, 1'b0);
    chk("rst_rd_a_valid", rd_a_valid, 1'b0);
    @(negedge clk) reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("idle_rd_a", rd_a, 16'h0000);
    chk("idle_valid", valid, 8'h00);
    chk("idle_wrap", inc_wrap, 1'b0);

    // Load / read
    @(negedge clk) begin wr_en = 1'b1; wr_addr = 3'd3; buswires = 16'hABCD; end
    @(negedge clk) begin wr_addr = 3'd5; buswires = 16'h1234; end
    @(negedge clk) begin wr_en = 1'b0; rd_addr_a = 3'd3; rd_addr_b = 3'd5; end
    #1;
    chk("load_rd_a", rd_a, 16'hABCD);
    chk("load_rd_b", rd_b, 16'h1234);
    chk("load_valid", valid, 8'h28);
    chk("load_rd_a_valid", rd_a_valid, 1'b1);

    // Bypass vs. no bypass, both ports on the written register
    @(negedge clk) begin
      wr_en = 1'b1; wr_addr = 3'd2; buswires = 16'h5A5A; rd_addr_a = 3'd2; rd_addr_b = 3'd2;
    end
    #1;
    chk("byp_rd_a", rd_a, 16'h5A5A);
    chk("byp_rd_a_valid", rd_a_valid, 1'b1);
    chk("byp_rd_b", rd_b, 16'h5A5A);
    chk("nobyp_rd_a_old", rd_a2, 16'h0000);
    chk("nobyp_rd_a_valid_old", rd_a_valid2, 1'b0);
    @(negedge clk) wr_en = 1'b0;
    #1;
    chk("nobyp_rd_a_new", rd_a2, 16'h5A5A);
    chk("nobyp_rd_a_valid_new", rd_a_valid2, 1'b1);
    chk("byp_valid", valid, 8'h2C);

    // Increment with wrap; increments are never bypassed
    @(negedge clk) begin wr_en = 1'b1; wr_addr = 3'd7; buswires = 16'hFFFE; rd_addr_a = 3'd7; end
    @(negedge clk) begin wr_en = 1'b0; inc_en = 1'b1; inc_addr = 3'd7; end
    #1;
    chk("inc0_rd_a", rd_a, 16'hFFFE);
    chk("inc0_wrap", inc_wrap, 1'b0);
    @(negedge clk);
    #1;
    chk("inc1_rd_a", rd_a, 16'hFFFF);
    chk("inc1_wrap", inc_wrap, 1'b0);
    @(negedge clk) inc_en = 1'b0;
    #1;
    chk("inc2_rd_a", rd_a, 16'h0000);
    chk("inc2_wrap", inc_wrap, 1'b1);
    chk("inc2_valid", valid, 8'hAC);
    @(negedge clk);
    #1;
    chk("inc3_wrap", inc_wrap, 1'b0);
    chk("inc3_rd_a", rd_a, 16'h0000);

    // Collision on an all-ones register: load wins, no wrap pulse
    @(negedge clk) begin wr_en = 1'b1; wr_addr = 3'd6; buswires = 16'hFFFF; end
    @(negedge clk) begin buswires = 16'h1234; inc_en = 1'b1; inc_addr = 3'd6; rd_addr_a = 3'd6; end
    @(negedge clk) begin wr_en = 1'b0; inc_en = 1'b0; end
    #1;
    chk("coll6_rd_a", rd_a, 16'h1234);
    chk("coll6_wrap", inc_wrap, 1'b0);

    // Collision on R1
    @(negedge clk) begin wr_en = 1'b1; wr_addr = 3'd1; buswires = 16'h0007; end
    @(negedge clk) begin buswires = 16'h0010; inc_en = 1'b1; inc_addr = 3'd1; rd_addr_a = 3'd1; end
    @(negedge clk) begin wr_en = 1'b0; inc_en = 1'b0; end
    #1;
    chk("coll1_rd_a", rd_a, 16'h0010);

    // Load and increment on different registers
    @(negedge clk) begin wr_en = 1'b1; wr_addr = 3'd1; buswires = 16'h0010; inc_en = 1'b1; inc_addr = 3'd0; end
    @(negedge clk) begin wr_en = 1'b0; inc_en = 1'b0; rd_addr_a = 3'd1; rd_addr_b = 3'd0; end
    #1;
    chk("split_r1", rd_a, 16'h0010);
    chk("split_r0", rd_b, 16'h0001);
    chk("split_r0_valid", rd_b_valid, 1'b0);
    chk("split_valid", valid, 8'hEE);

    // Async reset pulse between edges with a write pending
    @(negedge clk) begin wr_en = 1'b1; wr_addr = 3'd4; buswires = 16'hBEEF; rd_addr_a = 3'd3; rd_addr_b = 3'd4; end
    #1;
    chk("pre_rst_rd_a", rd_a, 16'hABCD);
    chk("pre_rst_byp_b", rd_b, 16'hBEEF);
    reset = 1'b1;
    #1;
    chk("arst_rd_a", rd_a, 16'h0000);
    chk("arst_rd_b", rd_b, 16'h0000);
    chk("arst_valid", valid, 8'h00);
    chk("arst_rd_a_valid", rd_a_valid, 1'b0);
    #2;
    reset = 1'b0; wr_en = 1'b0;
    @(negedge clk);
    #1;
    chk("post_pulse_valid", valid, 8'h00);
    chk("post_pulse_rd_b", rd_b, 16'h0000);

    // Reset held across an edge with wr_en high: nothing captured
    @(negedge clk) begin reset = 1'b1; wr_en = 1'b1; wr_addr = 3'd4; buswires = 16'hBEEF; end
    @(negedge clk) begin reset = 1'b0; wr_en = 1'b0; end
    #1;
    chk("held_rst_valid", valid, 8'h00);
    chk("held_rst_rd_b", rd_b, 16'h0000);
    chk("held_rst_wrap", inc_wrap, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
